// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI output stage.
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned DATA_BITS   = 12;
    localparam int unsigned SAMPLE_BITS = 8;
    localparam int unsigned GAIN_BITS   = 4;
    localparam int unsigned PD_BITS     = 2;
    localparam int unsigned CNT_BITS    = 5;

    // DAC121S101 power-down field encodings
    localparam logic [PD_BITS-1:0] PD_NORMAL = 2'b00;
    localparam logic [PD_BITS-1:0] PD_1K     = 2'b01;
    localparam logic [PD_BITS-1:0] PD_100K   = 2'b10;
    localparam logic [PD_BITS-1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    // Assemble the 16-bit DAC word: two don't-care zeros, power-down bits, code
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [PD_BITS-1:0]   pd,
        input logic [DATA_BITS-1:0] code
    );
        return {2'b00, pd, code};
    endfunction

endpackage

// File: rtl/dac_spi_if.sv
// Sample handshake bus between the waveform generator and the DAC stage.
interface dac_spi_if;
    import dac_spi_pkg::*;

    logic                   s_valid;
    logic [SAMPLE_BITS-1:0] s_data;
    logic                   s_ready;
    logic [GAIN_BITS-1:0]   gain;
    logic [PD_BITS-1:0]     pd_mode;

    modport master (output s_valid, s_data, gain, pd_mode, input s_ready);
    modport slave  (input s_valid, s_data, gain, pd_mode, output s_ready);
endinterface

// File: rtl/dac_spi_tick.sv
// sclk half-period divider: free-runs only while the frame engine is active.
module dac_spi_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLK_DIV-1, held at zero while idle
    always_ff @(posedge clk) begin
        if (clr || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);
endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC output stage: one 8-bit sample in, one 16-bit SPI frame out.
// Optional feature: define DAC_GAIN_EN to scale samples by gain (8x4 multiply).
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          clr,
    dac_spi_if.slave      bus,
    output logic          dac_sync_n,
    output logic          dac_sclk,
    output logic          dac_din,
    output logic          busy,
    output logic          frame_done
);
    state_t                state, state_d;
    logic [FRAME_BITS-1:0] sreg, sreg_d;
    logic [CNT_BITS-1:0]   bit_cnt, bit_cnt_d;
    logic                  ready, ready_d;
    logic                  sync_n_d, sclk_d, din_d, busy_d, frame_done_d;
    logic                  tick;
    logic [DATA_BITS-1:0]  code_c;
    logic [FRAME_BITS-1:0] frame_c;

    dac_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .clr  (clr),
        .run  (state != ST_IDLE),
        .tick (tick)
    );

`ifdef DAC_GAIN_EN
    // Scaled code; an 8x4 product always fits in 12 bits
    assign code_c = DATA_BITS'(bus.s_data) * DATA_BITS'(bus.gain);
`else
    // Replicate the top nibble so full scale maps to 0xFFF
    assign code_c = {bus.s_data, bus.s_data[SAMPLE_BITS-1 -: 4]};
    logic unused_gain;
    assign unused_gain = ^bus.gain;
`endif

    assign frame_c   = build_frame(bus.pd_mode, code_c);
    assign bus.s_ready = ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            ready      <= 1'b1;
            dac_sync_n <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            bit_cnt    <= bit_cnt_d;
            ready      <= ready_d;
            dac_sync_n <= sync_n_d;
            dac_sclk   <= sclk_d;
            dac_din    <= din_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and next-output logic for the frame engine
    always_comb begin
        state_d      = state;
        sreg_d       = sreg;
        bit_cnt_d    = bit_cnt;
        sync_n_d     = dac_sync_n;
        sclk_d       = dac_sclk;
        din_d        = dac_din;
        frame_done_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.s_valid && ready) begin
                    sreg_d    = frame_c;
                    bit_cnt_d = '0;
                    sync_n_d  = 1'b0;
                    sclk_d    = 1'b1;
                    din_d     = frame_c[FRAME_BITS-1];
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (dac_sclk) begin
                        // Falling edge: DAC samples the current bit
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt + CNT_BITS'(1);
                    end else if (bit_cnt == CNT_BITS'(FRAME_BITS)) begin
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        state_d  = ST_QUIET;
                    end else begin
                        // Rising edge: present the next bit
                        sclk_d = 1'b1;
                        sreg_d = {sreg[FRAME_BITS-2:0], 1'b0};
                        din_d  = sreg[FRAME_BITS-2];
                    end
                end
            end
            ST_QUIET: begin
                if (tick) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end
endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC output stage: accepts 8-bit waveform samples over a valid/ready handshake and shifts each one out as a 16-bit SPI frame to a 12-bit DAC121S101-class converter. The frame is sync_n, sclk, din, MSB first, with the DAC sampling on the sclk falling edge. The block sits directly downstream of the waveform generator and replaces its parallel data_gen/clk_da output pins with a 3-wire DAC port.

## Interface
- CLK_DIV, 2, clk cycles per sclk half-period; legal range ≥1. At 100 MHz, 2 gives 25 MHz sclk.
- clk  in  1  system clock (100 MHz domain).
- clr  in  1  synchronous, active-high reset.
- s_valid  in  1  sample offered.
- s_data  in  8  unsigned sample, 0..255.
- s_ready  out  1  high only in IDLE; transfer when s_valid && s_ready on a rising clk.
- gain  in  4  amplitude multiplier 0..15; used only with DAC_GAIN_EN.
- pd_mode  in  2  DAC power-down bits, sampled with s_data.
- dac_sync_n  out  1  frame select, active low.
- dac_sclk  out  1  serial clock, idles high.
- dac_din  out  1  serial data.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- States are IDLE, SHIFT, QUIET.
- Reset values: state IDLE, dac_sync_n 1, dac_sclk 1, dac_din 0, s_ready 1, busy 0, frame_done 0, all counters 0.
- Accept:
  - Latch frame = {2'b00, pd_mode, code12} into a 16-bit shift register.
  - Clear the divider and the bit counter.
  - Enter SHIFT.
- code12 without the macro: {s_data, s_data[7:4]}. 0x00→0x000, 0xFF→0xFFF.
- Divider: counts 0..CLK_DIV-1 only outside IDLE; tick when count == CLK_DIV-1.
- SHIFT entry: dac_sync_n 0, dac_sclk 1, dac_din = frame[15].
- Each tick in SHIFT toggles dac_sclk:
  - Falling edge (1→0): the DAC samples; bit counter increments.
  - Rising edge (0→1): shift register moves left; dac_din = next bit.
- After the 16th falling edge, the next tick:
  - dac_sclk 1, dac_sync_n 1, dac_din 0.
  - Enter QUIET.
- QUIET: one half-period. Its tick returns the block to IDLE and pulses frame_done.
- s_valid while not ready: ignored. The upstream either holds the sample or discards it; no internal buffering.
- s_valid while in IDLE: accepted unconditionally.
- clr mid-frame:
  - Next cycle all outputs return to reset values.
  - dac_sync_n rising before the 16th falling edge makes the DAC abort the partial frame; required behaviour.
- gain, pd_mode, s_data changes after accept do not affect the frame in flight.

## Timing
- Accept at cycle T0.
- Cycle T0+1:
  - dac_sync_n falls, s_ready 0, busy 1.
  - dac_din = bit15.
  - Setup time equals one half-period.
- Falling sclk edges at T0+1+(2k+1)·CLK_DIV, for k = 0..15.
- dac_sync_n low for exactly 32·CLK_DIV cycles, T0+1 .. T0+32·CLK_DIV.
- QUIET occupies T0+32·CLK_DIV+1 .. T0+33·CLK_DIV.
- Cycle T0+33·CLK_DIV+1: frame_done 1, s_ready 1, busy 0.
- Back-to-back accept is possible in that same cycle, giving a period of 33·CLK_DIV+1 cycles (67 at CLK_DIV=2).
- All outputs are registered; no combinational path from inputs to DAC pins.

## Configuration
- DAC_GAIN_EN defined:
  - code12 = s_data × gain, an unsigned 8×4 multiply giving 12 bits with no overflow.
  - The product is registered at accept, so latency is unchanged.
- DAC_GAIN_EN undefined:
  - gain is ignored and no multiplier is built.
  - The replication mapping above applies.

## Structure
- Package dac_spi_pkg holds:
  - the state enum;
  - FRAME_BITS = 16 and DATA_BITS = 12;
  - PD_NORMAL = 2'b00, PD_1K = 2'b01, PD_100K = 2'b10, PD_HIZ = 2'b11.
- Sub-module dac_spi_tick is the CLK_DIV divider. Inputs: clk, clr, run. Output: tick.
- Top-level integration: waveform_gen data_gen feeds s_data; its sample clock edge, synchronised into clk, drives s_valid.

## Test plan
- Reset, then s_data 0xA5 and pd_mode 00 with the macro off, at CLK_DIV=2:
  - sampling din on sclk falling edges captures 0x0A5A;
  - sync_n is low for 64 cycles;
  - frame_done arrives 67 cycles after accept.
- s_data 0xFF with pd_mode 01 → captured frame 0x1FFF; s_data 0x00 with pd_mode 11 → 0x3000.
- Macro on:
  - s_data 0x80, gain 8 → frame 0x0400;
  - s_data 0xFF, gain 15 → 0x0EF1;
  - gain 0 → 0x0000.
- s_valid held high continuously → frames every 67 cycles, each carrying the data present at its accept cycle; s_ready is low for 66 of every 67 cycles.
- clr asserted at the 5th falling edge → next cycle sync_n 1, sclk 1, din 0, s_ready 1; a following sample 0x3C is sent intact as 0x03C3.
- CLK_DIV=1 → sclk toggles every cycle, sync_n low 32 cycles, period 34 cycles, frame contents unchanged.
